// File: rtl/checker_pkg.sv
// Shared types and element-indexing helpers for result_checker.
// CHECKER_LOCATE_EN adds the SCAN state used to locate the first bad element.
`timescale 1ns/1ps
package checker_pkg;

    localparam int WIDTH_BIT = 2;
    localparam int INSTR_BIT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
`ifdef CHECKER_LOCATE_EN
        SCAN = 2'd2,
`endif
        DONE = 2'd3
    } state_t;

    // Element k (row-major) sits at the top of the packed matrix when k == 0.
    function automatic int elem_lsb(input int k, input int n, input int w);
        return (n - 1 - k) * w;
    endfunction

    function automatic int elem_row(input int k, input int width);
        return k / width;
    endfunction

    function automatic int elem_col(input int k, input int width);
        return k % width;
    endfunction

endpackage

// File: rtl/result_checker_ans_mem.sv
// Expected-result storage: one synchronous write port, one asynchronous read port.
// Deliberately has no reset so contents survive a checker reset.
`timescale 1ns/1ps
module ans_mem #(
    parameter int DEPTH = 16,
    parameter int DW    = 512,
    parameter int AW    = 4
) (
    input  logic          CLK,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge CLK) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/result_checker.sv
// Compares a stream of processor result matrices against stored expected matrices.
// Define CHECKER_LOCATE_EN to scan the first failing matrix for its first bad element.
`timescale 1ns/1ps
module result_checker
    import checker_pkg::*;
#(
    parameter int WIDTH  = 1 << WIDTH_BIT,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1 << INSTR_BIT,
    localparam int N  = WIDTH * WIDTH,
    localparam int MW = N * DATA_W,
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          St,
    input  logic [IW:0]   num_instr,
    input  logic          exp_we,
    input  logic [IW-1:0] exp_addr,
    input  logic [MW-1:0] exp_data,
    input  logic          res_valid,
    output logic          res_ready,
    input  logic [MW-1:0] result,
    output logic          busy,
    output logic          done,
    output logic [IW:0]   pass_cnt,
    output logic [IW:0]   fail_cnt,
    output logic [IW-1:0] first_fail_idx,
    output logic [CW-1:0] first_fail_row,
    output logic [CW-1:0] first_fail_col,
    output logic          any_fail
);

    localparam logic [IW:0]   ONE_N = 1;
    localparam logic [IW-1:0] ONE_I = 1;

    state_t        state, next_state;
    logic [IW-1:0] index;
    logic [IW:0]   num_reg;
    logic [MW-1:0] exp_rd;
    logic [N-1:0]  neq;
    logic          match, transfer, last, start, first_miss;

    ans_mem #(.DEPTH(DEPTH), .DW(MW), .AW(IW)) u_mem (
        .CLK   (CLK),
        .we    (exp_we),
        .waddr (exp_addr),
        .wdata (exp_data),
        .raddr (index),
        .rdata (exp_rd)
    );

    for (genvar k = 0; k < N; k++) begin : g_cmp
        localparam int LSB = elem_lsb(k, N, DATA_W);
        logic signed [DATA_W-1:0] r_elem, e_elem;
        assign r_elem = result[LSB +: DATA_W];
        assign e_elem = exp_rd[LSB +: DATA_W];
        assign neq[k] = (r_elem != e_elem);
    end

    // Handshake qualified by state directly so res_ready stays a pure FSM output.
    assign match      = ~|neq;
    assign transfer   = res_valid && (state == RUN);
    assign last       = ({1'b0, index} == (num_reg - ONE_N));
    assign start      = St && ((state == IDLE) || (state == DONE));
    assign first_miss = transfer && !match && !any_fail;

`ifdef CHECKER_LOCATE_EN
    localparam int EW = (N > 1) ? $clog2(N) : 1;
    localparam logic [EW-1:0] ONE_E = 1;

    logic [N-1:0]  neq_reg;
    logic [EW-1:0] scan_elem;
    logic          scan_last;
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        res_ready  = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (St) next_state = RUN;
            end
            RUN: begin
                res_ready = 1'b1;
                busy      = 1'b1;
                if (transfer) begin
`ifdef CHECKER_LOCATE_EN
                    if (first_miss) next_state = SCAN;
                    else
`endif
                    if (last) next_state = DONE;
                end
            end
`ifdef CHECKER_LOCATE_EN
            SCAN: begin
                busy = 1'b1;
                if (neq_reg[scan_elem]) next_state = scan_last ? DONE : RUN;
            end
`endif
            DONE: begin
                done = 1'b1;
                if (St) next_state = RUN;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            index          <= '0;
            num_reg        <= '0;
            pass_cnt       <= '0;
            fail_cnt       <= '0;
            any_fail       <= 1'b0;
            first_fail_idx <= '0;
        end else if (start) begin
            index          <= '0;
            num_reg        <= num_instr;
            pass_cnt       <= '0;
            fail_cnt       <= '0;
            any_fail       <= 1'b0;
            first_fail_idx <= '0;
        end else if (transfer) begin
            index <= index + ONE_I;
            if (match) begin
                pass_cnt <= pass_cnt + ONE_N;
            end else begin
                fail_cnt <= fail_cnt + ONE_N;
                if (!any_fail) begin
                    any_fail       <= 1'b1;
                    first_fail_idx <= index;
                end
            end
        end
    end

`ifdef CHECKER_LOCATE_EN
    // Snapshot of which elements differed, so later memory writes cannot disturb the scan.
    always_ff @(posedge CLK) begin
        if (first_miss) neq_reg <= neq;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            scan_elem      <= '0;
            scan_last      <= 1'b0;
            first_fail_row <= '0;
            first_fail_col <= '0;
        end else if (start) begin
            first_fail_row <= '0;
            first_fail_col <= '0;
        end else if (first_miss) begin
            scan_elem <= '0;
            scan_last <= last;
        end else if (state == SCAN) begin
            if (neq_reg[scan_elem]) begin
                first_fail_row <= CW'(elem_row(int'(scan_elem), WIDTH));
                first_fail_col <= CW'(elem_col(int'(scan_elem), WIDTH));
            end else begin
                scan_elem <= scan_elem + ONE_E;
            end
        end
    end
`else
    assign first_fail_row = '0;
    assign first_fail_col = '0;
`endif

endmodule

// File: tb/tb_result_checker.sv
// Directed, table-driven bench for result_checker (both CHECKER_LOCATE_EN builds).
`timescale 1ns/1ps
module tb_result_checker;

    localparam int WIDTH  = 4;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;
    localparam int N      = WIDTH * WIDTH;
    localparam int MW     = N * DATA_W;
`ifdef CHECKER_LOCATE_EN
    localparam bit LOC = 1'b1;
`else
    localparam bit LOC = 1'b0;
`endif

    logic          CLK, RST, St;
    logic [4:0]    num_instr;
    logic          exp_we;
    logic [3:0]    exp_addr;
    logic [MW-1:0] exp_data;
    logic          res_valid, res_ready;
    logic [MW-1:0] result;
    logic          busy, done, any_fail;
    logic [4:0]    pass_cnt, fail_cnt;
    logic [3:0]    first_fail_idx;
    logic [1:0]    first_fail_row, first_fail_col;

    int checks = 0;
    int errors = 0;
    int bubbles = 0;

    result_checker #(.WIDTH(WIDTH), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST(RST), .St(St), .num_instr(num_instr),
        .exp_we(exp_we), .exp_addr(exp_addr), .exp_data(exp_data),
        .res_valid(res_valid), .res_ready(res_ready), .result(result),
        .busy(busy), .done(done), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
        .first_fail_idx(first_fail_idx), .first_fail_row(first_fail_row),
        .first_fail_col(first_fail_col), .any_fail(any_fail)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [3:0] mask;
        int elem;
        int pass_e, fail_e, idx_e, row_e, col_e, bub_e, dwait_e;
    } rec_t;

    rec_t tbl[5];

    // Entry e, element k; element 5 is -1 everywhere, flip_k >= 0 toggles bit 0 there.
    function automatic logic [MW-1:0] mk(input int e, input int flip_k);
        logic [MW-1:0] m;
        logic signed [DATA_W-1:0] v;
        m = '0;
        for (int k = 0; k < N; k++) begin
            v = (k == 5) ? -32'sd1 : DATA_W'(e * 100 + k - 50);
            if (k == flip_k) v = v ^ 32'sd1;
            m[(N-1-k)*DATA_W +: DATA_W] = v;
        end
        return m;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic start_run(input int n);
        St = 1'b1;
        num_instr = 5'(n);
        @(negedge CLK);
        St = 1'b0;
    endtask

    task automatic send(input logic [MW-1:0] data);
        int waits;
        waits = 0;
        result = data;
        res_valid = 1'b1;
        while (!res_ready && waits < 100) begin
            @(negedge CLK);
            waits++;
            bubbles++;
        end
        if (waits >= 100) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: res_ready low for %0d cycles, expected high", waits);
        end
        @(negedge CLK);
        res_valid = 1'b0;
    endtask

    task automatic wait_done(input int exp_w);
        int w;
        w = 0;
        while (!done && w < 100) begin
            @(negedge CLK);
            w++;
        end
        chk("done_latency", 64'(w), 64'(exp_w));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_res_ready"}, 64'(res_ready), 0);
        chk({tag, "_busy"}, 64'(busy), 0);
        chk({tag, "_done"}, 64'(done), 0);
        chk({tag, "_any_fail"}, 64'(any_fail), 0);
        chk({tag, "_pass_cnt"}, 64'(pass_cnt), 0);
        chk({tag, "_fail_cnt"}, 64'(fail_cnt), 0);
        chk({tag, "_ff_idx"}, 64'(first_fail_idx), 0);
        chk({tag, "_ff_row"}, 64'(first_fail_row), 0);
        chk({tag, "_ff_col"}, 64'(first_fail_col), 0);
    endtask

    initial begin
        RST = 1'b0; St = 1'b0; num_instr = '0;
        exp_we = 1'b0; exp_addr = '0; exp_data = '0;
        res_valid = 1'b0; result = '0;

        tbl[0] = '{4'b0000,  0, 4, 0, 0, 0,          0,          0,           0};
        tbl[1] = '{4'b0100,  7, 3, 1, 2, LOC ? 1 : 0, LOC ? 3 : 0, LOC ? 8 : 0,  0};
        tbl[2] = '{4'b1010, 10, 2, 2, 1, LOC ? 2 : 0, LOC ? 2 : 0, LOC ? 11 : 0, 0};
        tbl[3] = '{4'b0001, 15, 3, 1, 0, LOC ? 3 : 0, LOC ? 3 : 0, LOC ? 16 : 0, 0};
        tbl[4] = '{4'b1000,  5, 3, 1, 3, LOC ? 1 : 0, LOC ? 1 : 0, 0,            LOC ? 6 : 0};

        repeat (3) @(negedge CLK);
        chk_all_zero("reset");
        RST = 1'b1;
        @(negedge CLK);

        for (int e = 0; e < 4; e++) begin
            exp_we = 1'b1;
            exp_addr = 4'(e);
            exp_data = mk(e, -1);
            @(negedge CLK);
        end
        exp_we = 1'b0;

        for (int r = 0; r < 5; r++) begin
            bubbles = 0;
            start_run(4);
            for (int e = 0; e < 4; e++) send(mk(e, tbl[r].mask[e] ? tbl[r].elem : -1));
            wait_done(tbl[r].dwait_e);
            chk($sformatf("r%0d_pass_cnt", r), 64'(pass_cnt), 64'(tbl[r].pass_e));
            chk($sformatf("r%0d_fail_cnt", r), 64'(fail_cnt), 64'(tbl[r].fail_e));
            chk($sformatf("r%0d_any_fail", r), 64'(any_fail), 64'(tbl[r].fail_e != 0));
            chk($sformatf("r%0d_ff_idx", r), 64'(first_fail_idx), 64'(tbl[r].idx_e));
            chk($sformatf("r%0d_ff_row", r), 64'(first_fail_row), 64'(tbl[r].row_e));
            chk($sformatf("r%0d_ff_col", r), 64'(first_fail_col), 64'(tbl[r].col_e));
            chk($sformatf("r%0d_ready_bubbles", r), 64'(bubbles), 64'(tbl[r].bub_e));
            chk($sformatf("r%0d_done", r), 64'(done), 1);
            chk($sformatf("r%0d_busy", r), 64'(busy), 0);
        end

        // St during RUN is ignored; St in DONE restarts with cleared counters.
        start_run(4);
        send(mk(0, -1));
        send(mk(1, -1));
        start_run(2);
        chk("st_run_busy", 64'(busy), 1);
        chk("st_run_pass", 64'(pass_cnt), 2);
        send(mk(2, -1));
        send(mk(3, -1));
        wait_done(0);
        chk("st_run_final_pass", 64'(pass_cnt), 4);
        chk("st_run_final_fail", 64'(fail_cnt), 0);
        start_run(4);
        chk("st_done_busy", 64'(busy), 1);
        chk("st_done_done", 64'(done), 0);
        chk("st_done_pass_clr", 64'(pass_cnt), 0);
        for (int e = 0; e < 4; e++) send(mk(e, -1));
        wait_done(0);
        chk("st_done_rerun_pass", 64'(pass_cnt), 4);

        // Write to the entry under comparison in the same cycle: old contents are used.
        start_run(1);
        exp_we = 1'b1;
        exp_addr = 4'd0;
        exp_data = mk(0, 0);
        send(mk(0, -1));
        exp_we = 1'b0;
        wait_done(0);
        chk("wr_same_cycle_pass", 64'(pass_cnt), 1);
        chk("wr_same_cycle_fail", 64'(fail_cnt), 0);
        start_run(1);
        send(mk(0, 0));
        wait_done(0);
        chk("wr_took_effect_pass", 64'(pass_cnt), 1);
        exp_we = 1'b1;
        exp_data = mk(0, -1);
        @(negedge CLK);
        exp_we = 1'b0;

        // Asynchronous reset in the middle of a run (mid-SCAN when locating).
        start_run(4);
        send(mk(0, -1));
        send(mk(1, 15));
        repeat (2) @(negedge CLK);
        chk("pre_rst_any_fail", 64'(any_fail), 1);
        chk("pre_rst_ff_idx", 64'(first_fail_idx), 1);
        chk("pre_rst_busy", 64'(busy), 1);
        RST = 1'b0;
        #1;
        chk_all_zero("midrun_rst");
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        start_run(4);
        for (int e = 0; e < 4; e++) send(mk(e, -1));
        wait_done(0);
        chk("post_rst_pass", 64'(pass_cnt), 4);
        chk("post_rst_fail", 64'(fail_cnt), 0);
        chk("post_rst_any_fail", 64'(any_fail), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
